// File: rtl/dmem_loader.sv
// dmem_loader
//   Parses framed bytes from a serial receiver and writes the payload into the
//   8 KB byte-wide data memory through its debug write port, one byte per
//   accepted payload byte. While a frame is in progress, `busy` holds the CPU
//   off the memory.
//
//   Frame: SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN payload bytes, CHK.
//   CHK is the 8-bit sum of everything between SYNC and CHK.
//
// Parameters
//   SYNC       frame start byte
//   TMO        max cycles between accepted bytes inside a frame (0 = off)
// Ports
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   rx_data    incoming byte
//   rx_vld     rx_data valid
//   rx_rdy     byte accepted when rx_vld & rx_rdy (always 1 out of reset)
//   debug      memory write strobe, one cycle per payload byte
//   data_cpu   write data to memory
//   waddr_cpu  write byte address to memory
//   busy       frame in progress
//   done       one-cycle pulse: frame completed with good checksum
//   err        one-cycle pulse: frame aborted (address/timeout) or bad checksum
module dmem_loader #(
  parameter logic [7:0]  SYNC = 8'hA5,
  parameter logic [15:0] TMO  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        rx_rdy,
  output logic        debug,
  output logic [7:0]  data_cpu,
  output logic [12:0] waddr_cpu,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AH,
    S_AL,
    S_LH,
    S_LL,
    S_DATA,
    S_CHK
  } state_t;

  state_t      state_reg,   state_next;
  logic [12:0] addr_reg,    addr_next;
  logic [15:0] len_reg,     len_next;
  logic [7:0]  sum_reg,     sum_next;
  logic [15:0] tmo_cnt_reg, tmo_cnt_next;
  logic        debug_reg,   debug_next;
  logic [7:0]  data_reg,    data_next;
  logic [12:0] waddr_reg,   waddr_next;
  logic        done_reg,    done_next;
  logic        err_reg,     err_next;
  logic        busy_reg;
  logic        rdy_reg;

  logic accept;
  logic timeout_hit;

  assign accept = rx_vld & rdy_reg;

  // The counter holds the number of idle cycles seen so far; the timeout fires
  // on the edge that would make it equal TMO. An accepted byte on that same
  // edge takes priority and simply restarts the count.
  assign timeout_hit = (TMO != 16'd0) && (state_reg != S_IDLE) && !accept &&
                       (({1'b0, tmo_cnt_reg} + 17'd1) == {1'b0, TMO});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      addr_reg    <= 13'd0;
      len_reg     <= 16'd0;
      sum_reg     <= 8'd0;
      tmo_cnt_reg <= 16'd0;
      debug_reg   <= 1'b0;
      data_reg    <= 8'd0;
      waddr_reg   <= 13'd0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      rdy_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      len_reg     <= len_next;
      sum_reg     <= sum_next;
      tmo_cnt_reg <= tmo_cnt_next;
      debug_reg   <= debug_next;
      data_reg    <= data_next;
      waddr_reg   <= waddr_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      busy_reg    <= (state_next != S_IDLE);
      rdy_reg     <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    len_next     = len_reg;
    sum_next     = sum_reg;
    debug_next   = 1'b0;
    data_next    = data_reg;
    waddr_next   = waddr_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    tmo_cnt_next = (accept || state_reg == S_IDLE) ? 16'd0 : tmo_cnt_reg + 16'd1;

    if (timeout_hit) begin
      state_next   = S_IDLE;
      err_next     = 1'b1;
      tmo_cnt_next = 16'd0;
    end else if (accept) begin
      case (state_reg)
        S_IDLE: begin
          if (rx_data == SYNC) begin
            state_next = S_AH;
            sum_next   = 8'd0;
            len_next   = 16'd0;
          end
        end
        S_AH: begin
          // Only 13 address bits exist; nonzero upper bits abort the frame.
          if (rx_data[7:5] != 3'd0) begin
            state_next = S_IDLE;
            err_next   = 1'b1;
          end else begin
            addr_next  = {rx_data[4:0], addr_reg[7:0]};
            sum_next   = sum_reg + rx_data;
            state_next = S_AL;
          end
        end
        S_AL: begin
          addr_next  = {addr_reg[12:8], rx_data};
          sum_next   = sum_reg + rx_data;
          state_next = S_LH;
        end
        S_LH: begin
          len_next   = {rx_data, 8'd0};
          sum_next   = sum_reg + rx_data;
          state_next = S_LL;
        end
        S_LL: begin
          len_next   = {len_reg[15:8], rx_data};
          sum_next   = sum_reg + rx_data;
          state_next = ({len_reg[15:8], rx_data} == 16'd0) ? S_CHK : S_DATA;
        end
        S_DATA: begin
          debug_next = 1'b1;
          data_next  = rx_data;
          waddr_next = addr_reg;
          addr_next  = addr_reg + 13'd1;  // natural 13-bit wrap 8191 -> 0
          len_next   = len_reg - 16'd1;
          sum_next   = sum_reg + rx_data;
          if (len_reg == 16'd1) begin
            state_next = S_CHK;
          end
        end
        S_CHK: begin
          state_next = S_IDLE;
          done_next  = (rx_data == sum_reg);
          err_next   = (rx_data != sum_reg);
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  assign rx_rdy    = rdy_reg;
  assign debug     = debug_reg;
  assign data_cpu  = data_reg;
  assign waddr_cpu = waddr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_dmem_loader.sv
// Testbench for dmem_loader: frame-level reference model feeding a scoreboard
// queue of expected writes / done / err pulses with the cycle they must appear.
module tb_dmem_loader;

  localparam logic [7:0]  SYNC_T = 8'hA5;
  localparam logic [15:0] TMO_T  = 16'd20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        rx_rdy;
  logic        debug;
  logic [7:0]  data_cpu;
  logic [12:0] waddr_cpu;
  logic        busy;
  logic        done;
  logic        err;

  dmem_loader #(.SYNC(SYNC_T), .TMO(TMO_T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_vld    (rx_vld),
    .rx_rdy    (rx_rdy),
    .debug     (debug),
    .data_cpu  (data_cpu),
    .waddr_cpu (waddr_cpu),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // kind: 0 = write, 1 = done, 2 = err
  typedef struct {
    int kind;
    int addr;
    int data;
    int stamp;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fr[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int a, input int d, input int st);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.stamp = st;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input int a, input int d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output kind=%0d actual=present required=none (cyc %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.stamp);
      if (kind == 0) begin
        check("waddr", a, e.addr);
        check("wdata", d, e.data);
      end
    end
  endtask

  // Monitor: every visible strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (debug) pop_cmp(0, int'(waddr_cpu), int'(data_cpu));
      if (done)  pop_cmp(1, 0, 0);
      if (err)   pop_cmp(2, 0, 0);
    end
  end

  // Presents a byte and returns the cycle stamp of its handshake edge, which
  // is also the stamp under which its registered response is sampled.
  task automatic send_byte(input logic [7:0] b, output int stamp);
    rx_vld  = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    stamp = cyc;
  endtask

  task automatic idle(input int n);
    rx_vld  = 1'b0;
    rx_data = 8'($urandom);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic gap(input int g);
    if (g < 0) idle(-g);
    else       idle(int'($urandom_range(g, 0)));
  endtask

  task automatic check_busy(input int req, input string name);
    @(negedge clk);
    check(name, int'(busy), req);
  endtask

  task automatic start_frame(input logic [7:0] ah, input logic [7:0] al,
                             input logic [7:0] lh, input logic [7:0] ll);
    fr = {SYNC_T, ah, al, lh, ll};
  endtask

  task automatic finish_frame(input bit corrupt);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 1; k < fr.size(); k++) s = s + fr[k];
    fr.push_back(corrupt ? s + 8'd1 : s);
  endtask

  // Frame-level reference model: derives expected writes and the final pulse
  // from the frame contents and handshake stamps.
  task automatic send_frame(input int g);
    int         st;
    int         base;
    int         len;
    logic [7:0] sum;
    gap(g); send_byte(fr[0], st); check_busy(1, "busy_after_sync");
    gap(g); send_byte(fr[1], st);
    if (fr[1][7:5] != 3'd0) begin
      push_ev(2, 0, 0, st);
      check_busy(0, "busy_after_addr_err");
      rx_vld = 1'b0;
      return;
    end
    check_busy(1, "busy_header");
    for (int k = 2; k < 5; k++) begin
      gap(g); send_byte(fr[k], st); check_busy(1, "busy_header");
    end
    base = int'({fr[1][4:0], fr[2]});
    len  = int'({fr[3], fr[4]});
    sum  = fr[1] + fr[2] + fr[3] + fr[4];
    for (int i = 0; i < len; i++) begin
      gap(g); send_byte(fr[5 + i], st);
      push_ev(0, (base + i) % 8192, int'(fr[5 + i]), st);
      sum = sum + fr[5 + i];
      check_busy(1, "busy_payload");
    end
    gap(g); send_byte(fr[5 + len], st);
    push_ev((fr[5 + len] == sum) ? 1 : 2, 0, 0, st);
    check_busy(0, "busy_after_chk");
    rx_vld = 1'b0;
  endtask

  initial begin
    int         st;
    int         len;
    logic [7:0] b;
    logic [7:0] garbage[3];

    rst_n   = 1'b0;
    rx_vld  = 1'b0;
    rx_data = 8'd0;
    #1;
    check("reset_rx_rdy", int'(rx_rdy), 0);
    check("reset_debug",  int'(debug), 0);
    check("reset_busy",   int'(busy), 0);
    check("reset_done",   int'(done), 0);
    check("reset_err",    int'(err), 0);
    #21 rst_n = 1'b1;
    #1 check("rx_rdy_before_edge", int'(rx_rdy), 0);
    @(posedge clk); #1;
    check("rx_rdy_after_edge", int'(rx_rdy), 1);
    idle(2);

    // basic three-byte frame, back to back
    start_frame(8'h00, 8'h10, 8'h00, 8'h03);
    fr.push_back(8'h11); fr.push_back(8'h22); fr.push_back(8'h33);
    finish_frame(1'b0);
    send_frame(0);

    // address wrap 0x1FFF -> 0x0000
    start_frame(8'h1F, 8'hFF, 8'h00, 8'h02);
    fr.push_back(8'hAA); fr.push_back(8'hBB);
    finish_frame(1'b0);
    send_frame(0);

    // bad checksum: writes still happen, err pulse
    start_frame(8'h00, 8'h10, 8'h00, 8'h03);
    fr.push_back(8'h11); fr.push_back(8'h22); fr.push_back(8'h33);
    fr.push_back(8'h00);
    send_frame(0);

    // garbage in IDLE, then a frame with illegal address high bits
    garbage = '{8'h00, 8'hFF, 8'h5A};
    foreach (garbage[k]) begin
      send_byte(garbage[k], st);
      check_busy(0, "busy_garbage");
    end
    idle(1);
    fr = {SYNC_T, 8'h20};
    send_frame(0);
    idle(3);

    // timeout after A5 00 00
    send_byte(SYNC_T, st);
    send_byte(8'h00, st);
    send_byte(8'h00, st);
    push_ev(2, 0, 0, st + int'(TMO_T));
    idle(int'(TMO_T) + 2);
    check_busy(0, "busy_after_timeout");

    // a frame whose inter-byte gaps sit one cycle under the timeout
    start_frame(8'h03, 8'h40, 8'h00, 8'h02);
    fr.push_back(8'h5C); fr.push_back(8'hC5);
    finish_frame(1'b0);
    send_frame(-(int'(TMO_T) - 1));

    // asynchronous reset mid-payload
    send_byte(SYNC_T, st);
    send_byte(8'h00, st);
    send_byte(8'h10, st);
    send_byte(8'h00, st);
    send_byte(8'h03, st);
    send_byte(8'h11, st);
    push_ev(0, 16'h010, 8'h11, st);
    rx_vld = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_debug",     int'(debug), 0);
    check("rst_data_cpu",  int'(data_cpu), 0);
    check("rst_waddr_cpu", int'(waddr_cpu), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_done",      int'(done), 0);
    check("rst_err",       int'(err), 0);
    check("rst_rx_rdy",    int'(rx_rdy), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rx_rdy_after_rst", int'(rx_rdy), 1);
    send_byte(8'h22, st); check_busy(0, "busy_orphan");
    send_byte(8'h33, st); check_busy(0, "busy_orphan");
    send_byte(8'h71, st); check_busy(0, "busy_orphan");
    idle(2);

    // LEN = 0
    start_frame(8'h00, 8'h05, 8'h00, 8'h00);
    finish_frame(1'b0);
    send_frame(0);

    // long frame wrapping the whole memory
    start_frame(8'h1F, 8'hFE, 8'h20, 8'h03);
    for (int i = 0; i < 8195; i++) fr.push_back(8'($urandom));
    finish_frame(1'b0);
    send_frame(0);

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        b = 8'($urandom);
        if (b == SYNC_T) b = 8'h00;
        send_byte(b, st);
        check_busy(0, "busy_random_garbage");
      end
      len = int'($urandom_range(24, 0));
      b = ($urandom_range(7, 0) == 0) ? 8'($urandom) : 8'($urandom_range(31, 0));
      start_frame(b, 8'($urandom), 8'(len >> 8), 8'(len));
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      finish_frame($urandom_range(4, 0) == 0);
      send_frame(3);
      if (fr[1][7:5] != 3'd0) idle(1);
    end

    idle(5);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
